mem_arbiter: RTL and testbench

Shares the single core memory bus between two requesters: instruction fetch (port F) and load/store (port M).
Each requester speaks the core memory-bus handshake: request_enable, mode, addr, wdata, wstrb out; response_enable and data back.
Requests are captured into per-port pending slots and issued one at a time to the downstream bus. Each response is routed back to the port that owns the outstanding transaction.
Sits between the fetch/mem stages and the memory/MMIO interconnect.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch F / load-store M) arbiter onto one memory bus; optional watchdog under MEMARB_TIMEOUT_EN.
// Latency: request edge -> bus request 1 cycle later; bus response -> port response 1 cycle later.
// Backpressure: one pending slot per port, one bus transaction outstanding; a request on a full slot is dropped and flagged.
module mem_arbiter #(
    parameter bit FETCH_FIRST    = 1'b0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        f_request_enable,
    input  logic        f_mode,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_wdata,
    input  logic [3:0]  f_wstrb,
    output logic        f_response_enable,
    output logic [31:0] f_data,
    input  logic        m_request_enable,
    input  logic        m_mode,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic        m_response_enable,
    output logic [31:0] m_data,
    output logic        request_enable,
    output logic        mode,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        response_enable,
    input  logic [31:0] data,
    output logic        busy,
    output logic        err_overrun,
    output logic        err_timeout
);

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state;
    logic   f_prev, m_prev;
    logic   f_pend, m_pend;
    logic   owner_m;
    req_t   f_slot, m_slot;

    logic   f_rise, m_rise;
    logic   to_hit, done, done_f, done_m;
    logic   grant_m;
    req_t   grant_req;

`ifdef MEMARB_TIMEOUT_EN
    logic [15:0] to_cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign err_timeout    = 1'b0;
`endif

    always_comb begin
        f_rise = f_request_enable & ~f_prev;
        m_rise = m_request_enable & ~m_prev;
`ifdef MEMARB_TIMEOUT_EN
        to_hit = (state == S_WAIT) && !response_enable &&
                 (({1'b0, to_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));
`else
        to_hit = 1'b0;
`endif
        done      = (state == S_WAIT) && (response_enable || to_hit);
        done_f    = done & ~owner_m;
        done_m    = done & owner_m;
        grant_m   = m_pend && (!f_pend || !FETCH_FIRST);
        grant_req = grant_m ? m_slot : f_slot;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= S_IDLE;
            f_prev            <= 1'b0;
            m_prev            <= 1'b0;
            f_pend            <= 1'b0;
            m_pend            <= 1'b0;
            owner_m           <= 1'b0;
            f_slot            <= '0;
            m_slot            <= '0;
            f_response_enable <= 1'b0;
            f_data            <= '0;
            m_response_enable <= 1'b0;
            m_data            <= '0;
            request_enable    <= 1'b0;
            mode              <= 1'b0;
            addr              <= '0;
            wdata             <= '0;
            wstrb             <= '0;
            busy              <= 1'b0;
            err_overrun       <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
            to_cnt            <= '0;
            err_timeout       <= 1'b0;
`endif
        end else begin
            f_prev            <= f_request_enable;
            m_prev            <= m_request_enable;
            request_enable    <= 1'b0;
            f_response_enable <= 1'b0;
            m_response_enable <= 1'b0;

            // Completion frees the owner's slot before this edge's new request is considered.
            if (done_f) f_pend <= 1'b0;
            if (done_m) m_pend <= 1'b0;

            if (f_rise) begin
                if (f_pend && !done_f) begin
                    err_overrun <= 1'b1;
                end else begin
                    f_pend <= 1'b1;
                    f_slot <= {f_mode, f_addr, f_wdata, f_wstrb};
                end
            end
            if (m_rise) begin
                if (m_pend && !done_m) begin
                    err_overrun <= 1'b1;
                end else begin
                    m_pend <= 1'b1;
                    m_slot <= {m_mode, m_addr, m_wdata, m_wstrb};
                end
            end

            case (state)
                S_IDLE: begin
                    if (f_pend || m_pend) begin
                        owner_m        <= grant_m;
                        mode           <= grant_req.mode;
                        addr           <= grant_req.addr;
                        wdata          <= grant_req.wdata;
                        wstrb          <= grant_req.wstrb;
                        request_enable <= 1'b1;
                        busy           <= 1'b1;
                        state          <= S_WAIT;
`ifdef MEMARB_TIMEOUT_EN
                        to_cnt         <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                        if (owner_m) begin
                            m_response_enable <= 1'b1;
                            m_data            <= response_enable ? data : 32'h0;
                        end else begin
                            f_response_enable <= 1'b1;
                            f_data            <= response_enable ? data : 32'h0;
                        end
`ifdef MEMARB_TIMEOUT_EN
                        if (!response_enable) err_timeout <= 1'b1;
`endif
                    end
`ifdef MEMARB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter; the bench plays the bus slave and predicts grants per transaction.
module tb_mem_arbiter;
    localparam bit FETCH_FIRST = 1'b0;
    localparam int TO          = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        f_request_enable = 1'b0, f_mode = 1'b0;
    logic [31:0] f_addr = '0, f_wdata = '0;
    logic [3:0]  f_wstrb = '0;
    logic        f_response_enable;
    logic [31:0] f_data;
    logic        m_request_enable = 1'b0, m_mode = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic        m_response_enable;
    logic [31:0] m_data;
    logic        request_enable, mode;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        response_enable = 1'b0;
    logic [31:0] data = '0;
    logic        busy, err_overrun, err_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    mem_arbiter #(.FETCH_FIRST(FETCH_FIRST), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .f_request_enable(f_request_enable), .f_mode(f_mode), .f_addr(f_addr),
        .f_wdata(f_wdata), .f_wstrb(f_wstrb),
        .f_response_enable(f_response_enable), .f_data(f_data),
        .m_request_enable(m_request_enable), .m_mode(m_mode), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_response_enable(m_response_enable), .m_data(m_data),
        .request_enable(request_enable), .mode(mode), .addr(addr),
        .wdata(wdata), .wstrb(wstrb),
        .response_enable(response_enable), .data(data),
        .busy(busy), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        t.mode  = 1'($urandom_range(0, 1));
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.wstrb = 4'($urandom_range(0, 15));
        return t;
    endfunction

    task automatic set_f(input txn_t t);
        f_mode = t.mode; f_addr = t.addr; f_wdata = t.wdata; f_wstrb = t.wstrb;
    endtask

    task automatic set_m(input txn_t t);
        m_mode = t.mode; m_addr = t.addr; m_wdata = t.wdata; m_wstrb = t.wstrb;
    endtask

    task automatic drive(input bit do_f, input bit do_m, input txn_t tf, input txn_t tm);
        set_f(tf); set_m(tm);
        f_request_enable = do_f;
        m_request_enable = do_m;
        tick;
        f_request_enable = 1'b0;
        m_request_enable = 1'b0;
    endtask

    task automatic check_issue(input string tag, input txn_t t);
        check({tag, "_req"},   request_enable, 1);
        check({tag, "_busy"},  busy, 1);
        check({tag, "_mode"},  mode, t.mode);
        check({tag, "_addr"},  addr, t.addr);
        check({tag, "_wdata"}, wdata, t.wdata);
        check({tag, "_wstrb"}, wstrb, t.wstrb);
    endtask

    // Called with the bus request visible; answers after lat cycles and checks the routed response.
    task automatic respond(input bit to_m, input int lat, input logic [31:0] d);
        for (int i = 1; i < lat; i++) begin
            tick;
            check("req_pulse", request_enable, 0);
            check("busy_wait", busy, 1);
            check("no_rsp_wait", f_response_enable | m_response_enable, 0);
        end
        response_enable = 1'b1;
        data = d;
        tick;
        response_enable = 1'b0;
        data = $urandom;
        check("owner_rsp", to_m ? m_response_enable : f_response_enable, 1);
        check("owner_data", to_m ? m_data : f_data, d);
        check("other_rsp", to_m ? f_response_enable : m_response_enable, 0);
        check("busy_done", busy, 0);
    endtask

    // kind: 0 = F only, 1 = M only, 2 = both on the same edge
    task automatic run_round(input int kind, input txn_t tf, input txn_t tm,
                             input int lat1, input int lat2,
                             input logic [31:0] d1, input logic [31:0] d2);
        bit first_m;
        first_m = (kind == 1) || (kind == 2 && !FETCH_FIRST);
        drive(kind != 1, kind != 0, tf, tm);
        tick;
        check_issue("grant1", first_m ? tm : tf);
        respond(first_m, lat1, d1);
        tick;
        check("rsp1_pulse", first_m ? m_response_enable : f_response_enable, 0);
        check("rsp1_hold", first_m ? m_data : f_data, d1);
        if (kind == 2) begin
            check_issue("grant2", first_m ? tf : tm);
            respond(!first_m, lat2, d2);
            tick;
            check("rsp2_pulse", first_m ? f_response_enable : m_response_enable, 0);
        end else begin
            check("no_second_req", request_enable, 0);
        end
    endtask

    initial begin
        txn_t ta, tb2;
        int   nreq;

        // Reset state
        #12;
        check("rst_req", request_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", addr, 0);
        check("rst_rsp", f_response_enable | m_response_enable, 0);
        check("rst_data", f_data | m_data, 0);
        check("rst_err", {err_overrun, err_timeout}, 0);
        rstn = 1'b1;
        tick;

        // Single F read
        ta = '{1'b0, 32'h100, 32'h0, 4'h0};
        run_round(0, ta, rnd_txn(), 3, 1, 32'hDEADBEEF, 0);

        // Simultaneous F and M; M is a full-word write
        tb2 = '{1'b1, 32'h200, 32'hCAFEF00D, 4'hF};
        run_round(2, rnd_txn(), tb2, 2, 2, 32'h11111111, 32'h22222222);
        check("no_overrun_tie", err_overrun, 0);

        // Owner re-requests on the same edge its response is delivered
        ta  = rnd_txn();
        tb2 = rnd_txn();
        drive(1, 0, ta, ta);
        tick;
        check_issue("rereq1", ta);
        tick;
        response_enable = 1'b1;
        data = 32'h5A5A0001;
        set_f(tb2);
        f_request_enable = 1'b1;
        tick;
        response_enable = 1'b0;
        f_request_enable = 1'b0;
        check("rereq_rsp", f_response_enable, 1);
        check("rereq_data", f_data, 32'h5A5A0001);
        tick;
        check_issue("rereq2", tb2);
        check("rereq_no_overrun", err_overrun, 0);
        respond(0, 1, 32'h5A5A0002);
        tick;

        // Bus response while idle is ignored
        response_enable = 1'b1;
        data = 32'hBADBAD00;
        tick;
        response_enable = 1'b0;
        check("idle_rsp_ignored", f_response_enable | m_response_enable, 0);
        check("idle_busy", busy, 0);
        check("idle_data", f_data, 32'h5A5A0002);

        // F held high: one transaction; second edge while pending flags overrun
        ta = rnd_txn();
        set_f(ta);
        f_request_enable = 1'b1;
        tick;
        tick;
        check_issue("hold", ta);
        nreq = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (request_enable) nreq++;
        end
        f_request_enable = 1'b0;
        tick;
        f_request_enable = 1'b1;
        tick;
        f_request_enable = 1'b0;
        tick;
        check("overrun_set", err_overrun, 1);
        respond(0, 1, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) begin
            tick;
            if (request_enable) nreq++;
        end
        check("hold_one_txn", nreq, 0);
        check("overrun_sticky", err_overrun, 1);

        // Reset during WAIT, late response afterwards
        drive(1, 0, rnd_txn(), rnd_txn());
        tick;
        check("pre_rst_req", request_enable, 1);
        tick;
        rstn = 1'b0;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_err", err_overrun, 0);
        check("midrst_addr", addr, 0);
        check("midrst_data", f_data, 0);
        rstn = 1'b1;
        response_enable = 1'b1;
        data = 32'h12345678;
        tick;
        response_enable = 1'b0;
        nreq = 0;
        for (int i = 0; i < 4; i++) begin
            if (request_enable | f_response_enable | m_response_enable | busy) nreq++;
            tick;
        end
        check("late_rsp_ignored", nreq, 0);
        check("late_data", f_data, 0);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            run_round($urandom_range(0, 2), rnd_txn(), rnd_txn(),
                      $urandom_range(1, 5), $urandom_range(1, 5), $urandom, $urandom);
            if ($urandom_range(0, 1) == 1) tick;
        end
        check("rand_no_overrun", err_overrun, 0);

`ifdef MEMARB_TIMEOUT_EN
        begin
            bit got;
            int n;
            ta = rnd_txn();
            drive(1, 0, ta, ta);
            tick;
            check_issue("to_grant", ta);
            got = 1'b0;
            n = 0;
            for (int i = 0; i < 50 && !got; i++) begin
                tick;
                n++;
                if (f_response_enable) got = 1'b1;
            end
            check("to_fired", got, 1);
            check("to_cycles", n, TO);
            check("to_data", f_data, 0);
            check("to_err", err_timeout, 1);
            check("to_busy", busy, 0);
            tick;
            run_round(1, rnd_txn(), rnd_txn(), 2, 1, 32'h600DD00D, 0);
            check("to_sticky", err_timeout, 1);
        end
`else
        check("no_timeout", err_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
